uart_arbiter: RTL and testbench

Shares one `uart_device` control port among `NUM_REQ` byte-producing requesters. It arbitrates round-robin and, optionally, holds the grant for multi-byte packets. For each granted byte it polls the device flags register for `write_ready` and then writes the byte into the transmit buffer. It sits between the processor-side peripherals that emit serial output and the `uart_device` instance.

---
 rtl/uart_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_arbiter.sv
`default_nettype none
// uart_arbiter: round-robin sharing of one uart_device control port among NUM_REQ byte producers.
// Optional feature: define UART_ARB_BAUD_INIT_EN to program BAUD_DIVIDER into device address 2 after reset.
module uart_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [15:0] BAUD_DIVIDER = 16'h0446
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic                 uart_control,
    output logic                 uart_write_enable,
    output logic [7:0]           uart_address,
    output logic [15:0]          uart_data_in,
    input  logic [15:0]          uart_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_POLL   = 3'd2,
        S_WRITE  = 3'd3,
        S_ACK    = 3'd4,
        S_LOCKED = 3'd5
    } state_t;

    state_t          state, next_state;
    logic [PW-1:0]   last, owner, win_idx, cand;
    logic            win_found;
    logic [7:0]      byte_q;
    logic            unused_dout;

    assign unused_dout = ^uart_data_out[15:1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef UART_ARB_BAUD_INIT_EN
            state <= S_INIT;
`else
            state <= S_IDLE;
`endif
        end else begin
            state <= next_state;
        end
    end

    // First pending requester strictly after the last owner, wrapping mod NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(last) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Bus outputs are decoded from state; gating with reset_n keeps them 0 while INIT is held in reset.
    always_comb begin
        next_state        = state;
        uart_control      = 1'b0;
        uart_write_enable = 1'b0;
        uart_address      = 8'h00;
        uart_data_in      = 16'h0000;
        busy              = reset_n && (state != S_IDLE);
        ack               = (reset_n && state == S_ACK) ? grant : '0;
        case (state)
            S_INIT: begin
                uart_control      = reset_n;
                uart_write_enable = reset_n;
                uart_address      = reset_n ? 8'h02 : 8'h00;
                uart_data_in      = reset_n ? BAUD_DIVIDER : 16'h0000;
                next_state        = S_IDLE;
            end
            S_IDLE: begin
                if (win_found) next_state = S_POLL;
            end
            S_POLL: begin
                uart_control = 1'b1;
                uart_address = 8'h01;
                if (uart_data_out[0]) next_state = S_WRITE;
            end
            S_WRITE: begin
                uart_control      = 1'b1;
                uart_write_enable = 1'b1;
                uart_address      = 8'h03;
                uart_data_in      = {8'h00, byte_q};
                next_state        = S_ACK;
            end
            S_ACK: begin
                next_state = lock[owner] ? S_LOCKED : S_IDLE;
            end
            S_LOCKED: begin
                if (!lock[owner])    next_state = S_IDLE;
                else if (req[owner]) next_state = S_POLL;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant  <= '0;
            owner  <= '0;
            byte_q <= 8'h00;
            last   <= PW'(NUM_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        owner  <= win_idx;
                        byte_q <= req_data[{win_idx, 3'b000} +: 8];
                    end
                end
                S_ACK: begin
                    if (!lock[owner]) begin
                        last  <= owner;
                        grant <= '0;
                    end
                end
                S_LOCKED: begin
                    if (!lock[owner]) begin
                        last  <= owner;
                        grant <= '0;
                    end else if (req[owner]) begin
                        byte_q <= req_data[{owner, 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_arbiter.sv
`default_nettype none
// Directed bench for uart_arbiter: stimulus pushes expected device writes and acks into queues,
// a negedge monitor pops and compares them whenever the DUT strobes a write or an ack.
module tb_uart_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req, lock, grant, ack;
    logic [31:0] req_data;
    logic        busy, uart_control, uart_write_enable;
    logic [7:0]  uart_address;
    logic [15:0] uart_data_in, uart_data_out;
    logic        ready;

    logic [2:0]  req3, grant3, ack3;
    logic [23:0] req_data3;
    logic        busy3, ctl3, we3;
    logic [7:0]  addr3;
    logic [15:0] din3;

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_wr[$];
    logic [3:0]  exp_ack[$];

    always #5 clock = ~clock;

    assign uart_data_out = (uart_address == 8'h01) ? {15'h0000, ready} : 16'h0000;

    uart_arbiter #(.NUM_REQ(4), .BAUD_DIVIDER(16'h0446)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .lock(lock), .req_data(req_data),
        .grant(grant), .ack(ack), .busy(busy), .uart_control(uart_control),
        .uart_write_enable(uart_write_enable), .uart_address(uart_address),
        .uart_data_in(uart_data_in), .uart_data_out(uart_data_out)
    );

    uart_arbiter #(.NUM_REQ(3), .BAUD_DIVIDER(16'h0446)) dut3 (
        .clock(clock), .reset_n(reset_n), .req(req3), .lock(3'b000), .req_data(req_data3),
        .grant(grant3), .ack(ack3), .busy(busy3), .uart_control(ctl3),
        .uart_write_enable(we3), .uart_address(addr3),
        .uart_data_in(din3), .uart_data_out(16'h0001)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (uart_control && uart_write_enable) begin
            if (exp_wr.size() == 0) check("write_unexpected", {40'h0, uart_address, uart_data_in}, 64'h0);
            else check("write", {40'h0, uart_address, uart_data_in}, {40'h0, exp_wr.pop_front()});
        end
        if (ack != 4'b0000) begin
            if (exp_ack.size() == 0) check("ack_unexpected", {60'h0, ack}, 64'h0);
            else check("ack", {60'h0, ack}, {60'h0, exp_ack.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req = '0; lock = '0; req_data = '0; ready = 1'b1;
        req3 = '0; req_data3 = '0;
        step(2);
        check("reset_outputs", {29'h0, grant, ack, busy, uart_control, uart_write_enable, uart_address, uart_data_in}, 64'h0);
`ifdef UART_ARB_BAUD_INIT_EN
        exp_wr.push_back({8'h02, 16'h0446});
`endif
        reset_n = 1'b1;
        step(2);
        check("idle_busy", {63'h0, busy}, 64'h0);

        // single request, device ready
        exp_wr.push_back({8'h03, 16'h0041});
        exp_ack.push_back(4'b0001);
        req = 4'b0001; req_data[7:0] = 8'h41;
        step(1);
        check("single_grant", {60'h0, grant}, 64'h1);
        check("single_poll", {54'h0, uart_control, uart_write_enable, uart_address}, {54'h0, 2'b10, 8'h01});
        step(1);
        check("single_write_cycle2", {63'h0, uart_write_enable}, 64'h1);
        step(1);
        check("single_ack_cycle3", {60'h0, ack}, 64'h1);
        req = 4'b0000;
        step(1);
        check("single_release", {60'h0, grant}, 64'h0);

        // contention: requesters 1 and 3 alternate
        req_data[15:8] = 8'h11; req_data[31:24] = 8'h33;
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back({8'h03, 16'h0011}); exp_ack.push_back(4'b0010);
            exp_wr.push_back({8'h03, 16'h0033}); exp_ack.push_back(4'b1000);
        end
        req = 4'b1010;
        step(1);
        check("contention_first_grant", {60'h0, grant}, 64'h2);
        step(14);
        req = 4'b0000;
        step(1);

        // backpressure: ten POLL cycles with write_ready low
        ready = 1'b0;
        req_data[23:16] = 8'h5A;
        exp_wr.push_back({8'h03, 16'h005A}); exp_ack.push_back(4'b0100);
        req = 4'b0100;
        step(1);
        for (int i = 0; i < 10; i++) begin
            check("backpressure_poll", {54'h0, uart_control, uart_write_enable, uart_address}, {54'h0, 2'b10, 8'h01});
            if (i < 9) step(1);
        end
        ready = 1'b1;
        step(1);
        check("backpressure_write", {55'h0, uart_write_enable, uart_address}, {55'h0, 1'b1, 8'h03});
        step(1);
        check("backpressure_ack", {60'h0, ack}, 64'h4);
        req = 4'b0000;
        step(1);

        // packet lock: requester 2 sends three bytes while requester 0 waits
        exp_wr.push_back({8'h03, 16'h00A1}); exp_ack.push_back(4'b0100);
        exp_wr.push_back({8'h03, 16'h00A2}); exp_ack.push_back(4'b0100);
        exp_wr.push_back({8'h03, 16'h00A3}); exp_ack.push_back(4'b0100);
        exp_wr.push_back({8'h03, 16'h000F}); exp_ack.push_back(4'b0001);
        req = 4'b0100; lock = 4'b0100; req_data[23:16] = 8'hA1;
        step(1);
        req = 4'b0101; req_data[7:0] = 8'h0F;
        step(2);
        req_data[23:16] = 8'hA2;
        step(1);
        check("locked_grant_held", {58'h0, grant, busy, uart_control}, {58'h0, 4'b0100, 1'b1, 1'b0});
        step(3);
        req_data[23:16] = 8'hA3;
        step(4);
        lock = 4'b0000; req = 4'b0001;
        step(1);
        check("lock_release_idle", {60'h0, grant}, 64'h0);
        step(1);
        check("lock_then_req0", {60'h0, grant}, 64'h1);
        step(2);
        req = 4'b0000;
        step(1);

        // reset pulse while stuck in POLL
        ready = 1'b0;
        req = 4'b0010; req_data[15:8] = 8'h77;
        step(2);
        check("midpoll_busy", {63'h0, busy}, 64'h1);
        reset_n = 1'b0;
        #1;
        check("midpoll_reset_outputs", {29'h0, grant, ack, busy, uart_control, uart_write_enable, uart_address, uart_data_in}, 64'h0);
        req = 4'b0000; ready = 1'b1;
        step(1);
`ifdef UART_ARB_BAUD_INIT_EN
        exp_wr.push_back({8'h02, 16'h0446});
`endif
        reset_n = 1'b1;
        step(3);
        check("after_reset_idle", {59'h0, grant, busy}, 64'h0);

        // wrap-around on the three-requester instance: serve 2 first, then 0 must follow
        req3 = 3'b100; req_data3 = 24'h332211;
        begin
            int n = 0;
            while (ack3 == 3'b000 && n < 20) begin
                step(1);
                n++;
            end
            check("wrap_first_ack", {61'h0, ack3}, 64'h4);
        end
        req3 = 3'b111;
        step(2);
        check("wrap_grant0", {61'h0, grant3}, 64'h1);
        req3 = 3'b000;
        step(4);

        check("write_queue_drained", 64'(exp_wr.size()), 64'h0);
        check("ack_queue_drained", 64'(exp_ack.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
